// File: rtl/sda_out_ctrl_if.sv
// SDA output controller bus bundle: pad levels, controller mode/TX bit and status.
// master = slave-controller/pad side that drives the inputs, slave = sda_out_ctrl.
interface sda_out_ctrl_if;
    logic       scl_in;
    logic       sda_in;
    logic [1:0] sda_mode;
    logic       tx_out;
    logic       clear_collision;
    logic       sda_out;
    logic       sda_oe;
    logic       hold_busy;
    logic       collision;

    modport master (
        output scl_in, sda_in, sda_mode, tx_out, clear_collision,
        input  sda_out, sda_oe, hold_busy, collision
    );

    modport slave (
        input  scl_in, sda_in, sda_mode, tx_out, clear_collision,
        output sda_out, sda_oe, hold_busy, collision
    );
endinterface

// File: rtl/sda_out_ctrl.sv
// Registered SDA output controller: updates SDA only HOLD_CYCLES after each synced SCL fall.
// Optional collision detection/forced release is built when SDA_COLLISION_DETECT_EN is defined.
module sda_out_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    sda_out_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        TRACK  = 2'd2,
        FROZEN = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sda_q;
    logic             sda_fsm;
    logic             sda_nxt;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic                   scl_s;
    logic                   scl_q;
    logic                   fall;
    logic                   rise;
    logic                   target;

    // SCL synchroniser; resets to 1 so an idle bus produces no spurious edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            scl_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
            scl_q    <= scl_s;
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign fall  = scl_q & ~scl_s;
    assign rise  = ~scl_q & scl_s;

    always_comb begin
        target = 1'b1;
        case (bus.sda_mode)
            2'b00:   target = 1'b1;
            2'b01:   target = 1'b0;
            2'b10:   target = 1'b1;
            2'b11:   target = bus.tx_out;
            default: target = 1'b1;
        endcase
    end

    // Release (mode 00) overrides every state transition
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sda_fsm   = sda_q;
        if (bus.sda_mode == 2'b00) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            sda_fsm   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    sda_fsm = 1'b1;
                    if (scl_s) begin
                        state_nxt = FROZEN;
                    end else begin
                        state_nxt = HOLD;
                        cnt_nxt   = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (rise) begin
                        state_nxt = FROZEN;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_ONE) begin
                        state_nxt = TRACK;
                        cnt_nxt   = '0;
                        sda_fsm   = target;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                TRACK: begin
                    if (rise) begin
                        state_nxt = FROZEN;
                    end else begin
                        sda_fsm = target;
                    end
                end
                FROZEN: begin
                    if (fall) begin
                        state_nxt = HOLD;
                        cnt_nxt   = HOLD_LOAD;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    sda_fsm   = 1'b1;
                end
            endcase
        end
    end

`ifdef SDA_COLLISION_DETECT_EN
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   sda_s;
    logic                   coll_q;
    logic                   coll_set;
    logic                   coll_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_sync <= '1;
        end else begin
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
        end
    end

    assign sda_s = sda_sync[SYNC_STAGES-1];

    // We released SDA but the bus reads low as SCL rises: another master owns the bit
    assign coll_set = (bus.sda_mode == 2'b11) & rise & sda_q & ~sda_s;
    assign coll_nxt = coll_set | (coll_q & ~bus.clear_collision);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_nxt;
        end
    end

    assign sda_nxt       = coll_nxt ? 1'b1 : sda_fsm;
    assign bus.collision = coll_q;
`else
    assign sda_nxt       = sda_fsm;
    assign bus.collision = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sda_q <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sda_q <= sda_nxt;
        end
    end

    assign bus.sda_out   = sda_q;
    assign bus.sda_oe    = ~sda_q;
    assign bus.hold_busy = (state == HOLD);

endmodule

// File: tb/tb_sda_out_ctrl.sv
// Bench for sda_out_ctrl: directed scenarios with literal expectations plus a random run,
// all checked every cycle against a window-counting model of the SDA update rules.
module tb_sda_out_ctrl;
    localparam int H = 4;
    localparam int S = 2;
`ifdef SDA_COLLISION_DETECT_EN
    localparam bit COLL_ON = 1'b1;
`else
    localparam bit COLL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sda_out_ctrl_if bus ();
    sda_out_ctrl #(.HOLD_CYCLES(H), .SYNC_STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passes = 0;

    logic       c_scl, c_sda, c_tx, c_clr;
    logic [1:0] c_mode;

    // Model: pin history for synced levels, and the count of low SCL cycles in the current window
    logic hs [4];
    logic hd [4];
    logic m_sq, m_sda, m_coll;
    bit   m_eng;
    int   m_win;

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            hs[k] = 1'b1;
            hd[k] = 1'b1;
        end
        m_sq = 1'b1; m_sda = 1'b1; m_coll = 1'b0; m_eng = 1'b0; m_win = -1;
    endtask

    task automatic model_step();
        logic ss, ds, tgt, rise_m, set_m;
        ss = hs[S-1];
        ds = hd[S-1];
        case (bus.sda_mode)
            2'b01:   tgt = 1'b0;
            2'b11:   tgt = bus.tx_out;
            default: tgt = 1'b1;
        endcase
        rise_m = ss && !m_sq;
        set_m  = COLL_ON && (bus.sda_mode == 2'b11) && rise_m && m_sda && !ds;
        if (bus.sda_mode == 2'b00) begin
            m_sda = 1'b1; m_eng = 1'b0; m_win = -1;
        end else if (!m_eng) begin
            m_eng = 1'b1;
            m_win = ss ? -1 : 0;
        end else if (ss) begin
            m_win = -1;
        end else begin
            if (m_win < H) m_win++;
            if (m_win >= H) m_sda = tgt;
        end
        m_coll = COLL_ON && (set_m || (m_coll && !bus.clear_collision));
        if (m_coll) m_sda = 1'b1;
        m_sq = ss;
        for (int k = 3; k > 0; k--) begin
            hs[k] = hs[k-1];
            hd[k] = hd[k-1];
        end
        hs[0] = bus.scl_in;
        hd[0] = bus.sda_in;
    endtask

    task automatic check_all();
        logic busy_m;
        busy_m = (m_win >= 0) && (m_win < H);
        chk_bit("sda_out", bus.sda_out, m_sda);
        chk_bit("sda_oe", bus.sda_oe, ~m_sda);
        chk_bit("hold_busy", bus.hold_busy, busy_m);
        chk_bit("collision", bus.collision, m_coll);
    endtask

    task automatic drive();
        bus.scl_in = c_scl;
        bus.sda_in = c_sda;
        bus.sda_mode = c_mode;
        bus.tx_out = c_tx;
        bus.clear_collision = c_clr;
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        drive();
        model_step();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic reset_literals(input string tag);
        chk_bit({tag, "_sda_out"}, bus.sda_out, 1'b1);
        chk_bit({tag, "_sda_oe"}, bus.sda_oe, 1'b0);
        chk_bit({tag, "_hold_busy"}, bus.hold_busy, 1'b0);
        chk_bit({tag, "_collision"}, bus.collision, 1'b0);
    endtask

    task automatic release_reset();
        rst = 1'b0;
        drive();
        model_step();
    endtask

    // Called just after a negedge: assert reset between edges, check, release on the next negedge
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 reset_literals(tag);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        release_reset();
    endtask

    initial begin
        int  bf, bc, sf, run_left;
        logic v0;
        bit  same;

        rst = 1'b1;
        c_scl = 1'b1; c_sda = 1'b1; c_mode = 2'b00; c_tx = 1'b0; c_clr = 1'b0;
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_literals("por");
        release_reset();

        // Hold timing: SCL dropped at pin, busy seen 4 samples, SDA falls when busy ends
        c_mode = 2'b01;
        run(6);
        chk_bit("frozen_start_sda", bus.sda_out, 1'b1);
        c_scl = 1'b0; bf = -1; bc = 0; sf = -1;
        for (int j = 1; j <= 12; j++) begin
            cyc();
            if (bus.hold_busy === 1'b1) begin
                bc++;
                if (bf < 0) bf = j;
            end
            if (bus.sda_out === 1'b0 && sf < 0) sf = j;
        end
        chk_int("hold_busy_first", bf, 4);
        chk_int("hold_busy_len", bc, H);
        chk_int("sda_fall_sample", sf, 8);

        // Reset asserted mid-HOLD while SDA is driven low
        c_scl = 1'b1;
        run(6);
        chk_bit("frozen_low_sda", bus.sda_out, 1'b0);
        c_scl = 1'b0;
        run(5);
        chk_bit("mid_hold_busy", bus.hold_busy, 1'b1);
        chk_bit("mid_hold_sda", bus.sda_out, 1'b0);
        c_scl = 1'b1; c_mode = 2'b01;
        async_reset("midhold");
        run(8);
        chk_bit("post_reset_sda", bus.sda_out, 1'b1);
        chk_bit("post_reset_busy", bus.hold_busy, 1'b0);

        // Freeze: toggling tx_out while SCL high must not move SDA
        c_mode = 2'b11; same = 1'b1; v0 = 1'bx;
        for (int j = 0; j < 10; j++) begin
            c_tx = 1'(j % 2);
            cyc();
            if (j == 0) v0 = bus.sda_out;
            else if (bus.sda_out !== v0) same = 1'b0;
        end
        chk_bit("freeze_const", same, 1'b1);
        chk_bit("freeze_level", v0, 1'b1);
        c_tx = 1'b0; c_scl = 1'b0;
        run(7);
        chk_bit("freeze_pre_update", bus.sda_out, 1'b1);
        cyc();
        chk_bit("freeze_update", bus.sda_out, 1'b0);

        // Early rise: two synced low cycles abort HOLD, SDA keeps its level
        c_scl = 1'b1;
        run(6);
        c_tx = 1'b1; c_scl = 1'b0; bc = 0; same = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            if (j == 3) c_scl = 1'b1;
            cyc();
            if (bus.hold_busy === 1'b1) bc++;
            if (bus.sda_out !== 1'b0) same = 1'b0;
        end
        chk_bit("early_rise_sda_held", same, 1'b1);
        chk_int("early_rise_busy_len", bc, 2);
        chk_bit("early_rise_busy_end", bus.hold_busy, 1'b0);

        // Mode 00 override while SCL high
        c_mode = 2'b01; c_scl = 1'b0;
        run(9);
        c_scl = 1'b1;
        run(4);
        chk_bit("m00_before", bus.sda_out, 1'b0);
        c_mode = 2'b00;
        cyc();
        chk_bit("m00_pre", bus.sda_out, 1'b0);
        cyc();
        chk_bit("m00_release", bus.sda_out, 1'b1);
        chk_bit("m00_busy", bus.hold_busy, 1'b0);

        // Collision: bus held low across a rise while we release
        c_mode = 2'b11; c_tx = 1'b1; c_sda = 1'b1;
        run(3);
        c_scl = 1'b0;
        run(10);
        chk_bit("coll_setup_sda", bus.sda_out, 1'b1);
        c_sda = 1'b0; c_scl = 1'b1;
        run(4);
        chk_bit("coll_set", bus.collision, COLL_ON);
        c_tx = 1'b0; c_sda = 1'b1;
        run(3);
        c_scl = 1'b0;
        run(10);
        chk_bit("coll_forced_release", bus.sda_out, COLL_ON);
        chk_bit("coll_sticky", bus.collision, COLL_ON);
        c_scl = 1'b1;
        run(4);
        c_clr = 1'b1;
        cyc();
        c_clr = 1'b0;
        cyc();
        chk_bit("coll_cleared", bus.collision, 1'b0);
        c_tx = 1'b1; c_scl = 1'b0;
        run(10);
        c_sda = 1'b0; c_scl = 1'b1;
        cyc();
        cyc();
        c_clr = 1'b1;
        cyc();
        c_clr = 1'b0;
        cyc();
        chk_bit("coll_set_wins", bus.collision, COLL_ON);
        c_sda = 1'b1; c_clr = 1'b1;
        cyc();
        c_clr = 1'b0;
        run(2);

        // Random traffic against the model, with one asynchronous reset in the middle
        run_left = 1;
        for (int i = 0; i < 3000; i++) begin
            run_left--;
            if (run_left <= 0) begin
                c_scl = ~c_scl;
                run_left = $urandom_range(1, 10);
            end
            if ($urandom_range(0, 29) == 0) c_mode = 2'($urandom_range(0, 3));
            c_tx  = 1'($urandom_range(0, 1));
            c_sda = ($urandom_range(0, 3) != 0);
            c_clr = ($urandom_range(0, 15) == 0);
            cyc();
            if (i == 1500) async_reset("rand");
        end
        cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
